// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the write-back FIFO entry.
package cpu_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // One queued mul/div result; valid drops when a newer pipeline write kills it.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rw;
        logic [DATA_W-1:0]     data;
    } wbEntry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of mul/div results with kill-by-address and skip-on-pop.
// Killed entries keep their slot until the next pop steps over them, or until
// the buffer holds no valid entry at all, at which point every slot is reclaimed.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [REG_ADDR_W-1:0]        pushRw,
    input  logic [DATA_W-1:0]            pushData,
    input  logic                         pop,
    input  logic                         killEn,
    input  logic [REG_ADDR_W-1:0]        killRw,
    input  logic [REG_ADDR_W-1:0]        qa,
    input  logic [REG_ADDR_W-1:0]        qb,
    output wbEntry_t                     head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         matchA,
    output logic                         matchB
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wbEntry_t         slots  [DEPTH];
    wbEntry_t         slotsD [DEPTH];
    logic [PTR_W-1:0] headPtr, headPtrD;
    logic [CNT_W-1:0] cnt, cntD;
    logic [PTR_W-1:0] tailPtr;
    logic [PTR_W-1:0] headIdx;
    logic [PTR_W-1:0] skip;
    logic             anyValid;

    function automatic logic [PTR_W-1:0] wrapAdd(input logic [PTR_W-1:0] base,
                                                 input int unsigned      off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= DEPTH) sum = sum - DEPTH;
        return PTR_W'(sum);
    endfunction

    // Locate the oldest valid entry and how many killed slots sit in front of it.
    always_comb begin
        anyValid = 1'b0;
        skip     = '0;
        headIdx  = headPtr;
        for (int i = 0; i < DEPTH; i++) begin
            if (!anyValid && slots[wrapAdd(headPtr, i)].valid) begin
                anyValid = 1'b1;
                skip     = PTR_W'(i);
                headIdx  = wrapAdd(headPtr, i);
            end
        end
    end

    assign tailPtr = wrapAdd(headPtr, 32'(cnt));
    assign head    = slots[headIdx];
    assign count   = cnt;
    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = !anyValid;

    // Pending-write match against the two decode-stage source registers.
    always_comb begin
        matchA = 1'b0;
        matchB = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slots[i].valid && slots[i].rw == qa) matchA = 1'b1;
            if (slots[i].valid && slots[i].rw == qb) matchB = 1'b1;
        end
        if (qa == REG_ZERO) matchA = 1'b0;
        if (qb == REG_ZERO) matchB = 1'b0;
    end

    // Next state: kill, then reclaim or pop, then append the new result.
    always_comb begin
        slotsD   = slots;
        headPtrD = headPtr;
        cntD     = cnt;
        for (int i = 0; i < DEPTH; i++) begin
            if (killEn && slotsD[i].valid && slotsD[i].rw == killRw) slotsD[i].valid = 1'b0;
        end
        if (!anyValid) begin
            // Only dead slots remain; unoccupied slots are always invalid.
            headPtrD = tailPtr;
            cntD     = '0;
        end else if (pop) begin
            slotsD[headIdx].valid = 1'b0;
            headPtrD = wrapAdd(headIdx, 1);
            cntD     = cnt - CNT_W'(skip) - CNT_W'(1);
        end
        if (push) begin
            slotsD[tailPtr] = '{valid: 1'b1, rw: pushRw, data: pushData};
            cntD            = cntD + CNT_W'(1);
        end
    end

    // Buffer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots   <= '{default: '0};
            headPtr <= '0;
            cnt     <= '0;
        end else begin
            slots   <= slotsD;
            headPtr <= headPtrD;
            cnt     <= cntD;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: the in-order pipeline always wins, mul/div
// results queue and drain in idle cycles, and a starvation counter raises a
// stall request when the queue has been blocked for too long.
module wb_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rw,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  md_valid,
    output logic                  md_ready,
    input  logic [REG_ADDR_W-1:0] md_rw,
    input  logic [DATA_W-1:0]     md_data,
    input  logic [REG_ADDR_W-1:0] qa,
    input  logic [REG_ADDR_W-1:0] qb,
    output logic                  hit_a,
    output logic                  hit_b,
    output logic                  stall_req,
    output logic                  RegWr,
    output logic [REG_ADDR_W-1:0] Rw,
    output logic [DATA_W-1:0]     busW
);

    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    wbEntry_t            fifoHead;
    logic [CNT_W-1:0]    fifoCount;
    logic                fifoFull;
    logic                fifoEmpty;
    logic                fifoMatchA;
    logic                fifoMatchB;
    logic                wbWin;
    logic                pushEn;
    logic                popEn;
    logic                blocked;
    logic [STARVE_W-1:0] starveCnt;

    assign wbWin    = wb_valid && (wb_rw != REG_ZERO);
    assign md_ready = !fifoFull;
    // A $0 result is accepted (handshake completes) but never stored.
    assign pushEn   = md_valid && md_ready && (md_rw != REG_ZERO);
    assign popEn    = !wbWin && !fifoEmpty;
    assign blocked  = wbWin && !fifoEmpty;

    assign hit_a = fifoMatchA || (RegWr && (Rw == qa) && (qa != REG_ZERO));
    assign hit_b = fifoMatchB || (RegWr && (Rw == qb) && (qb != REG_ZERO));

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (pushEn),
        .pushRw   (md_rw),
        .pushData (md_data),
        .pop      (popEn),
        .killEn   (wbWin),
        .killRw   (wb_rw),
        .qa       (qa),
        .qb       (qb),
        .head     (fifoHead),
        .count    (fifoCount),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .matchA   (fifoMatchA),
        .matchB   (fifoMatchB)
    );

    // Priority mux into the registered write port; idle cycles hold Rw/busW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWr <= 1'b0;
            Rw    <= REG_ZERO;
            busW  <= '0;
        end else if (wbWin) begin
            RegWr <= 1'b1;
            Rw    <= wb_rw;
            busW  <= wb_data;
        end else if (popEn) begin
            RegWr <= 1'b1;
            Rw    <= fifoHead.rw;
            busW  <= fifoHead.data;
        end else begin
            RegWr <= 1'b0;
        end
    end

    // Count consecutive blocked cycles; any non-blocked cycle is a pop or an empty queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starveCnt <= '0;
            stall_req <= 1'b0;
        end else if (blocked) begin
            if (starveCnt < STARVE_W'(STARVE_MAX)) starveCnt <= starveCnt + STARVE_W'(1);
            if (starveCnt >= STARVE_W'(STARVE_MAX - 1)) stall_req <= 1'b1;
        end else begin
            starveCnt <= '0;
            stall_req <= 1'b0;
        end
    end

    // Occupancy never exceeds DEPTH, and the head entry is valid exactly when non-empty.
    assert property (@(posedge clk) disable iff (rst) fifoCount <= CNT_W'(DEPTH));
    assert property (@(posedge clk) disable iff (rst) fifoEmpty != fifoHead.valid);

endmodule
